// File: rtl/accel_read_sequencer_if.sv
// Signal bundle between the accelerometer read sequencer, its byte-level SPI master
// and the axis data router.
interface accel_read_sequencer_if;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rx_data;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_cs_n;
    logic        Load;
    logic [1:0]  Byte_Count;
    logic [15:0] DataOut;

    modport master (
        input  spi_busy, spi_done, spi_rx_data,
        output spi_start, spi_tx_data, spi_cs_n, Load, Byte_Count, DataOut
    );

    modport slave (
        output spi_busy, spi_done, spi_rx_data,
        input  spi_start, spi_tx_data, spi_cs_n, Load, Byte_Count, DataOut
    );
endinterface

// File: rtl/accel_read_sequencer.sv
// Periodic ADXL362 burst reader: one 8-byte SPI burst per sample period, delivering
// X, Y and Z as little-endian 16-bit words to the axis router.
module accel_read_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned CS_SETUP_CYC  = 4,
    parameter int unsigned CS_HOLD_CYC   = 8,
    parameter logic [7:0]  CMD_READ      = 8'h0B,
    parameter logic [7:0]  START_ADDR    = 8'h0E
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    accel_read_sequencer_if.master bus,
    output logic                   sample_done,
    output logic                   overrun
);
    localparam int unsigned TW   = $clog2(SAMPLE_PERIOD);
    localparam int unsigned CMAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEND,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  low_q, low_d;
    logic        spi_start_q, spi_start_d;
    logic [7:0]  spi_tx_q, spi_tx_d;
    logic        cs_n_q, cs_n_d;
    logic        load_q, load_d;
    logic [1:0]  byte_count_q, byte_count_d;
    logic [15:0] data_q, data_d;
    logic        sample_done_q, sample_done_d;
    logic        overrun_q, overrun_d;
    logic        tick;
    logic [7:0]  tx_byte;

    assign tick = (timer_q == TW'(SAMPLE_PERIOD - 1));

    always_comb begin
        case (idx_q)
            3'd0:    tx_byte = CMD_READ;
            3'd1:    tx_byte = START_ADDR;
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = tick ? '0 : timer_q + TW'(1);
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        low_d         = low_q;
        spi_start_d   = 1'b0;
        spi_tx_d      = spi_tx_q;
        cs_n_d        = cs_n_q;
        load_d        = 1'b0;
        byte_count_d  = byte_count_q;
        data_d        = data_q;
        sample_done_d = 1'b0;
        overrun_d     = overrun_q | (tick && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    cs_n_d  = 1'b0;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP_CYC - 1)) begin
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEND: begin
                if (!bus.spi_busy) begin
                    spi_start_d = 1'b1;
                    spi_tx_d    = tx_byte;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    // Bytes 0/1 echo the command phase; data starts at byte 2, low byte first.
                    if (!idx_q[0]) begin
                        if (idx_q != 3'd0) begin
                            low_d = bus.spi_rx_data;
                        end
                    end else if (idx_q != 3'd1) begin
                        load_d       = 1'b1;
                        data_d       = {bus.spi_rx_data, low_q};
                        // Index 3/5/7 maps to axis tag 2/1/0.
                        byte_count_d = 2'd3 - idx_q[2:1];
                    end
                    if (idx_q == 3'd7) begin
                        cs_n_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD_CYC - 1)) begin
                    sample_done_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            low_q         <= 8'h00;
            spi_start_q   <= 1'b0;
            spi_tx_q      <= 8'h00;
            cs_n_q        <= 1'b1;
            load_q        <= 1'b0;
            byte_count_q  <= 2'd0;
            data_q        <= 16'h0000;
            sample_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            low_q         <= low_d;
            spi_start_q   <= spi_start_d;
            spi_tx_q      <= spi_tx_d;
            cs_n_q        <= cs_n_d;
            load_q        <= load_d;
            byte_count_q  <= byte_count_d;
            data_q        <= data_d;
            sample_done_q <= sample_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.spi_start   = spi_start_q;
    assign bus.spi_tx_data = spi_tx_q;
    assign bus.spi_cs_n    = cs_n_q;
    assign bus.Load        = load_q;
    assign bus.Byte_Count  = byte_count_q;
    assign bus.DataOut     = data_q;
    assign sample_done     = sample_done_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_accel_read_sequencer.sv
// Randomized scoreboard bench for accel_read_sequencer: an SPI device model serves the
// burst and queues the expected axis words; a monitor pops them on every Load.
module tb_accel_read_sequencer;
    localparam int P = 256;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic sample_done;
    logic overrun;

    accel_read_sequencer_if bus();

    accel_read_sequencer #(
        .SAMPLE_PERIOD(P),
        .CS_SETUP_CYC (4),
        .CS_HOLD_CYC  (8),
        .CMD_READ     (8'h0B),
        .START_ADDR   (8'h0E)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .sample_done(sample_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int busy_len = 10;
    int stall_at = -1;
    int byte_idx = 0;
    int txn_starts = 0;
    logic [7:0]  byte_q[$];
    logic [17:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for n more completed samples, bounded by a cycle budget.
    task automatic applyStimulus(input int n_txn, input int budget);
        int target = done_cnt + n_txn;
        int cyc = 0;
        while (done_cnt < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt < target) checkOutput("txn_timeout", done_cnt, target);
        #1;
    endtask

    // ADXL362 + byte-level SPI master model: busy for busy_len cycles per byte, then a done pulse.
    initial begin : spi_model
        int busy_cnt = 0;
        int stall_cnt = 0;
        int k;
        bit start_now;
        logic [7:0] cur[8];
        logic [7:0] exp_tx;
        bus.spi_busy    = 1'b0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            if (rst) begin
                bus.spi_busy = 1'b0;
                busy_cnt = 0;
                stall_cnt = 0;
                byte_idx = 0;
                txn_starts = 0;
                continue;
            end
            start_now = bus.spi_start;
            if (start_now) begin
                k = byte_idx;
                checkOutput("start_while_busy", (busy_cnt > 0 || stall_cnt > 0), 0);
                checkOutput("cs_low_at_start", bus.spi_cs_n, 0);
                checkOutput("byte_index_range", (k < 8), 1);
                exp_tx = (k == 0) ? 8'h0B : (k == 1) ? 8'h0E : 8'h00;
                checkOutput("tx_byte", bus.spi_tx_data, exp_tx);
                if (k == 0) begin
                    cur[0] = 8'($urandom);
                    cur[1] = 8'($urandom);
                end else if (k == 2) begin
                    for (int i = 2; i < 8; i++)
                        cur[i] = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
                    exp_q.push_back({2'd2, cur[3], cur[2]});
                    exp_q.push_back({2'd1, cur[5], cur[4]});
                    exp_q.push_back({2'd0, cur[7], cur[6]});
                end
                byte_idx++;
                txn_starts++;
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) bus.spi_busy = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.spi_busy    = 1'b0;
                    bus.spi_done    = 1'b1;
                    bus.spi_rx_data = (byte_idx >= 1 && byte_idx <= 8) ? cur[byte_idx - 1] : 8'h00;
                    if (byte_idx == stall_at) begin
                        bus.spi_busy = 1'b1;
                        stall_cnt = 20;
                        stall_at = -1;
                    end
                end
            end
            if (start_now) begin
                bus.spi_busy = 1'b1;
                busy_cnt = busy_len;
            end
            if (bus.spi_cs_n && busy_cnt == 0 && stall_cnt == 0) byte_idx = 0;
        end
    end

    // Monitor: scoreboard pops on Load, plus a period/overrun reference model.
    initial begin : monitor
        int ref_timer = 0;
        bit ref_active = 1'b0;
        bit ref_ov = 1'b0;
        bit post_rst = 1'b0;
        int pend = -1;
        int loads = 0;
        logic [17:0] e;
        logic [15:0] last_z = 16'h0;
        forever begin
            @(negedge clk);
            if (post_rst) begin
                checkOutput("reset_state",
                    {bus.spi_cs_n, bus.spi_start, bus.Load, sample_done, overrun,
                     bus.Byte_Count, bus.DataOut, bus.spi_tx_data},
                    {1'b1, 4'b0, 2'b0, 16'h0, 8'h0});
                post_rst = 1'b0;
            end
            if (rst) begin
                ref_timer = 0;
                ref_active = 1'b0;
                ref_ov = 1'b0;
                pend = -1;
                loads = 0;
                last_z = 16'h0;
                exp_q.delete();
                post_rst = 1'b1;
                continue;
            end
            if (pend >= 0) begin
                checkOutput("cs_after_tick", bus.spi_cs_n, pend);
                pend = -1;
            end
            checkOutput("overrun_flag", overrun, ref_ov);
            if (bus.Load) begin
                loads++;
                if (exp_q.size() == 0) begin
                    checkOutput("load_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("load_count", bus.Byte_Count, e[17:16]);
                    checkOutput("load_data", bus.DataOut, e[15:0]);
                    last_z = e[15:0];
                end
            end
            if (sample_done) begin
                checkOutput("starts_per_txn", txn_starts, 8);
                checkOutput("loads_per_txn", loads, 3);
                checkOutput("hold_data", {bus.Byte_Count, bus.DataOut}, {2'd0, last_z});
                txn_starts = 0;
                loads = 0;
                done_cnt++;
                ref_active = 1'b0;
            end
            if (ref_timer == P - 1) begin
                if (ref_active) begin
                    ref_ov = 1'b1;
                end else begin
                    pend = enable ? 0 : 1;
                    if (enable) ref_active = 1'b1;
                end
                ref_timer = 0;
            end else begin
                ref_timer++;
            end
        end
    end

    initial begin : stimulus
        int cs_low;
        int d0;
        int cyc;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] normal read");
        enable = 1'b1;
        busy_len = 10;
        byte_q = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h0F};
        applyStimulus(1, 1500);

        $display("[TB] negative data");
        byte_q = '{8'h00, 8'hF0, 8'h00, 8'h80, 8'hFE, 8'hFF};
        applyStimulus(1, 1500);

        $display("[TB] random data");
        applyStimulus(3, 4000);

        $display("[TB] busy stall before byte 3");
        stall_at = 3;
        byte_q = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h0F};
        applyStimulus(1, 1500);

        $display("[TB] enable dropped mid-transaction");
        cyc = 0;
        while (byte_idx < 3 && cyc < 1500) begin
            @(posedge clk);
            cyc++;
        end
        if (byte_idx < 3) checkOutput("enable_wait_timeout", byte_idx, 3);
        #1 enable = 1'b0;
        applyStimulus(1, 1500);
        d0 = done_cnt;
        cs_low = 0;
        repeat (3 * P) begin
            @(negedge clk);
            if (!bus.spi_cs_n) cs_low++;
        end
        checkOutput("cs_low_while_disabled", cs_low, 0);
        checkOutput("no_sample_while_disabled", done_cnt, d0);
        @(posedge clk);
        #1 enable = 1'b1;
        applyStimulus(2, 2000);

        $display("[TB] overrun");
        busy_len = 40;
        applyStimulus(2, 3000);
        checkOutput("overrun_sticky", overrun, 1);

        $display("[TB] reset mid-transaction");
        busy_len = 10;
        cyc = 0;
        while (!(byte_idx == 5 && bus.spi_busy) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (byte_idx != 5) checkOutput("reset_wait_timeout", byte_idx, 5);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 1500);
        checkOutput("overrun_after_reset", overrun, 0);

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
